// File: rtl/vrf_wb_queue_pkg.sv
// Shared vector-unit types for the VRF writeback path: register index, reservation-station
// reference and the writeback descriptor that the per-unit queues buffer.
package vrf_wb_queue_pkg;

  localparam int VRF_INDEX_W        = 5;
  localparam int RS_REF_W           = 4;
  localparam int VRF_WB_QUEUE_DEPTH = 4;

  typedef logic [VRF_INDEX_W-1:0] vrf_index_t;
  typedef logic [RS_REF_W-1:0]    rs_ref_t;

  typedef struct packed {
    logic       en;
    logic       we;
    vrf_index_t addr;
    rs_ref_t    rs_ref;
  } wb_desc_t;

endpackage

// File: rtl/vrf_wb_queue.sv
// Per-vector-unit writeback request FIFO: buffers result descriptors, presents the head to the
// VRF writeback arbiter, pops on ack, and answers pending-write lookups for RAW stalls.
module vrf_wb_queue
  import vrf_wb_queue_pkg::*;
#(
  parameter int DEPTH = VRF_WB_QUEUE_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       push_en,
  input  logic                       push_we,
  input  vrf_index_t                 push_addr,
  input  rs_ref_t                    push_ref,
  output logic                       full,
  output logic                       overflow,
  output logic                       req,
  input  logic                       ack,
  output logic                       wb_en,
  output logic                       wb_we,
  output vrf_index_t                 wb_addr,
  output rs_ref_t                    wb_ref,
  input  vrf_index_t                 chk_addr,
  output logic                       chk_hit,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef logic [PW-1:0] ptr_t;

  wb_desc_t mem [DEPTH];
  ptr_t     rd_ptr;
  ptr_t     wr_ptr;
  logic     push_acc;
  logic     pop;
  wb_desc_t head;

  // full comes from the registered count only, so a same-cycle ack never admits a push.
  assign full     = (count == CW'(DEPTH));
  assign req      = (count != '0);
  assign push_acc = push & ~full;
  assign pop      = req & ack;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)      rd_ptr <= rd_ptr + ptr_t'(1);
      count <= count + CW'(push_acc) - CW'(pop);
      if (push && full) overflow <= 1'b1;
    end
  end

  // NOTE: storage has no reset; validity is tracked entirely by rd_ptr/count.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= '{en: push_en, we: push_we, addr: push_addr, rs_ref: push_ref};
  end

  assign head    = req ? mem[rd_ptr] : '0;
  assign wb_en   = head.en;
  assign wb_we   = head.we;
  assign wb_addr = head.addr;
  assign wb_ref  = head.rs_ref;

  // Entry i is valid when its distance from the head is below the occupancy.
  // NOTE: outputs of always_comb get a default first so no path infers a latch.
  always_comb begin
    ptr_t offset;
    chk_hit = 1'b0;
    offset  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = ptr_t'(i) - rd_ptr;
      if ((CW'(offset) < count) && mem[i].we && (mem[i].addr == chk_addr)) chk_hit = 1'b1;
    end
  end

endmodule

// File: tb/tb_vrf_wb_queue.sv
// Directed bench for vrf_wb_queue: a table of per-cycle vectors plus hand-written wrap,
// async-reset and pending-write lookup sequences.
module tb_vrf_wb_queue;
  import vrf_wb_queue_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       push, push_en, push_we, ack;
  vrf_index_t push_addr, wb_addr, chk_addr;
  rs_ref_t    push_ref, wb_ref;
  logic       full, overflow, req, wb_en, wb_we, chk_hit;
  logic [2:0] count;

  int tests  = 0;
  int failed = 0;

  vrf_wb_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .push(push), .push_en(push_en), .push_we(push_we),
    .push_addr(push_addr), .push_ref(push_ref), .full(full), .overflow(overflow),
    .req(req), .ack(ack), .wb_en(wb_en), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_ref(wb_ref), .chk_addr(chk_addr), .chk_hit(chk_hit), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Inputs applied on the falling edge; expected outputs describe the state before the next rising edge.
  typedef struct {
    int push; int we; int addr; int ack; int chk;
    int e_req; int e_full; int e_count; int e_addr; int e_hit; int e_ovf;
  } vec_t;

  vec_t vecs[12];
  int   model_q[$];

  task automatic drive(input int p, input int we, input int a, input int k, input int c);
    push      = p[0];
    push_en   = 1'b1;
    push_we   = we[0];
    push_addr = vrf_index_t'(a);
    push_ref  = rs_ref_t'(a);
    ack       = k[0];
    chk_addr  = vrf_index_t'(c);
  endtask

  initial begin
    //         push we addr ack chk | req full cnt addr hit ovf
    vecs[0]  = '{1, 1, 5, 0, 0,   0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 1, 5,   1, 0, 1, 5, 1, 0};  // popped entry still visible
    vecs[2]  = '{0, 1, 0, 1, 5,   0, 0, 0, 0, 0, 0};  // ack with empty queue ignored
    vecs[3]  = '{1, 1, 1, 0, 1,   0, 0, 0, 0, 0, 0};  // entry being pushed not visible
    vecs[4]  = '{1, 1, 2, 0, 9,   1, 0, 1, 1, 0, 0};
    vecs[5]  = '{1, 1, 3, 0, 9,   1, 0, 2, 1, 0, 0};
    vecs[6]  = '{1, 1, 4, 0, 9,   1, 0, 3, 1, 0, 0};
    vecs[7]  = '{1, 1, 8, 0, 4,   1, 1, 4, 1, 1, 0};  // push while full dropped
    vecs[8]  = '{1, 1, 9, 1, 8,   1, 1, 4, 1, 0, 1};  // push+ack while full: push dropped
    vecs[9]  = '{0, 1, 0, 0, 9,   1, 0, 3, 2, 0, 1};
    vecs[10] = '{0, 1, 0, 1, 4,   1, 0, 3, 2, 1, 1};
    vecs[11] = '{0, 1, 0, 0, 3,   1, 0, 2, 3, 1, 1};

    drive(0, 0, 0, 0, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", req, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_wb_addr", wb_addr, 0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].push, vecs[i].we, vecs[i].addr, vecs[i].ack, vecs[i].chk);
      #1;
      check($sformatf("v%0d_req", i), req, vecs[i].e_req);
      check($sformatf("v%0d_full", i), full, vecs[i].e_full);
      check($sformatf("v%0d_count", i), count, vecs[i].e_count);
      check($sformatf("v%0d_wb_addr", i), wb_addr, vecs[i].e_addr);
      check($sformatf("v%0d_wb_ref", i), wb_ref, vecs[i].e_addr % 16);
      check($sformatf("v%0d_wb_en", i), wb_en, vecs[i].e_req);
      check($sformatf("v%0d_hit", i), chk_hit, vecs[i].e_hit);
      check($sformatf("v%0d_ovf", i), overflow, vecs[i].e_ovf);
    end

    // Eight simultaneous push/pop pairs from count=2 wrap both pointers twice.
    model_q = '{3, 4};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      drive(1, 1, 10 + k, 1, 31);
      #1;
      check($sformatf("wrap%0d_head", k), wb_addr, model_q[0]);
      check($sformatf("wrap%0d_count", k), count, 2);
      void'(model_q.pop_front());
      model_q.push_back(10 + k);
    end
    @(negedge clk);
    drive(1, 1, 20, 0, 20);
    #1;
    check("wrap_end_head", wb_addr, model_q[0]);
    check("wrap_end_count", count, 2);

    // Three entries queued, then asynchronous reset between clock edges.
    @(negedge clk);
    drive(0, 0, 0, 0, 20);
    #1;
    check("pre_rst_count", count, 3);
    check("pre_rst_hit", chk_hit, 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_req", req, 0);
    check("async_rst_count", count, 0);
    check("async_rst_hit", chk_hit, 0);
    check("async_rst_ovf", overflow, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 1, 20);
    repeat (2) begin
      @(negedge clk);
      #1;
      check("post_rst_req", req, 0);
      check("post_rst_count", count, 0);
    end

    // Pending-write lookup: {7, we=1}, {3, we=0}.
    @(negedge clk);
    drive(1, 1, 7, 0, 0);
    @(negedge clk);
    drive(1, 0, 3, 0, 7);
    @(negedge clk);
    drive(0, 0, 0, 0, 7);
    #1;
    check("lk_count", count, 2);
    check("lk_hit7", chk_hit, 1);
    chk_addr = vrf_index_t'(3);
    #1;
    check("lk_hit3_we0", chk_hit, 0);
    @(negedge clk);
    drive(0, 0, 0, 1, 7);
    @(negedge clk);
    drive(0, 0, 0, 0, 7);
    #1;
    check("lk_after_pop_hit7", chk_hit, 0);
    check("lk_after_pop_head", wb_addr, 3);
    check("lk_after_pop_we", wb_we, 0);
    check("lk_after_pop_count", count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
